// File: rtl/jtframe_dwnld_pack.sv
// ---------------------------------------------------------------------------
// jtframe_dwnld_pack
//
// Packs the byte-wide ioctl ROM download stream into 16-bit SDRAM words with
// byte masks. Words go through a small FIFO and are presented to the SDRAM
// controller programming port under a prog_we / prog_ack handshake.
//
// Parameters
//   SDRAMW     : SDRAM word-address width
//   FIFO_DEPTH : word FIFO entries (power of two, >= 2)
//   SWAB       : 1 places the even byte in prog_data[15:8]
//
// Ports
//   clk, rst          : clock, asynchronous active-high reset
//   downloading       : high during the whole ROM download
//   ioctl_addr/dout/wr: byte address, byte data, one-cycle byte strobe
//   prog_addr/data/mask/we : word write request (mask bit set = byte skipped)
//   prog_ack          : one-cycle acceptance of the presented word
//   dwnld_busy        : download or write-back still in progress
//   overflow          : sticky, a word was dropped on a full FIFO
//   cksum             : 16-bit byte sum of the download, present only when
//                       JTFRAME_DWNLD_CKSUM_EN is defined
// ---------------------------------------------------------------------------
module jtframe_dwnld_pack #(
   parameter int SDRAMW     = 22,
   parameter int FIFO_DEPTH = 4,
   parameter int SWAB       = 0
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              downloading,
   input  logic [24:0]       ioctl_addr,
   input  logic [7:0]        ioctl_dout,
   input  logic              ioctl_wr,
   output logic [SDRAMW-1:0] prog_addr,
   output logic [15:0]       prog_data,
   output logic [1:0]        prog_mask,
   output logic              prog_we,
   input  logic              prog_ack,
   output logic              dwnld_busy,
`ifdef JTFRAME_DWNLD_CKSUM_EN
   output logic [15:0]       cksum,
`endif
   output logic              overflow
);

   localparam int PW = $clog2(FIFO_DEPTH);

   typedef struct packed {
      logic [SDRAMW-1:0] addr;
      logic [15:0]       data;
      logic [1:0]        mask;
   } word_t;

   // Builds a word from its even (lo) and odd (hi) bytes. The mask follows
   // the data lanes, so with SWAB the even byte's mask moves to bit 1.
   function automatic word_t make_word(
      input logic [SDRAMW-1:0] a,
      input logic [7:0]        lo,
      input logic [7:0]        hi,
      input logic              vlo,
      input logic              vhi
   );
      word_t w;
      logic  lane_lo_v;
      logic  lane_hi_v;
      w.addr = a;
      if (SWAB != 0) begin
         w.data    = {lo, hi};
         lane_hi_v = vlo;
         lane_lo_v = vhi;
      end else begin
         w.data    = {hi, lo};
         lane_hi_v = vhi;
         lane_lo_v = vlo;
      end
      w.mask = {~lane_hi_v, ~lane_lo_v};
      return w;
   endfunction

   // Address bits above the SDRAM range are deliberately dropped
   generate
      if (SDRAMW < 24) begin : g_addr_unused
         logic unused_addr_hi;
         assign unused_addr_hi = ^ioctl_addr[24:SDRAMW+1];
      end
   endgenerate

   logic              downloading_p1;
   logic              dl_rise;
   logic              dl_fall;
   logic              acc;
   logic              odd;
   logic [SDRAMW-1:0] waddr;

   assign acc     = downloading & ioctl_wr;
   assign odd     = ioctl_addr[0];
   assign waddr   = ioctl_addr[SDRAMW:1];
   assign dl_rise = downloading & ~downloading_p1;
   assign dl_fall = ~downloading & downloading_p1;

   // Partial word (only ever holds an even byte) and one-entry skid
   logic              part_v;
   logic [SDRAMW-1:0] part_addr;
   logic [7:0]        part_lo;
   logic              skid_v;
   word_t             skid_w;

   logic              part_v_nxt;
   logic [SDRAMW-1:0] part_addr_nxt;
   logic [7:0]        part_lo_nxt;

   // Words produced by this cycle's byte: new_a is older than new_b
   word_t stale_w;
   word_t odd_w;
   word_t new_a;
   word_t new_b;
   logic  new_a_v;
   logic  new_b_v;

   // w0 is pushed now, w1 waits in the skid register for the next cycle
   word_t w0;
   word_t w1;
   logic  w0_v;
   logic  w1_v;

   always_comb begin
      stale_w       = make_word(part_addr, part_lo, 8'h00, 1'b1, 1'b0);
      odd_w         = make_word(waddr, 8'h00, ioctl_dout, 1'b0, 1'b1);
      new_a         = '0;
      new_b         = '0;
      new_a_v       = 1'b0;
      new_b_v       = 1'b0;
      part_v_nxt    = part_v;
      part_addr_nxt = part_addr;
      part_lo_nxt   = part_lo;
      if (acc) begin
         if (!odd) begin
            if (part_v && (part_addr != waddr)) begin
               new_a   = stale_w;
               new_a_v = 1'b1;
            end
            part_v_nxt    = 1'b1;
            part_addr_nxt = waddr;
            part_lo_nxt   = ioctl_dout;
         end else begin
            part_v_nxt = 1'b0;
            if (part_v && (part_addr == waddr)) begin
               new_a   = make_word(waddr, part_lo, ioctl_dout, 1'b1, 1'b1);
               new_a_v = 1'b1;
            end else if (part_v) begin
               new_a   = stale_w;
               new_a_v = 1'b1;
               new_b   = odd_w;
               new_b_v = 1'b1;
            end else begin
               new_a   = odd_w;
               new_a_v = 1'b1;
            end
         end
      end else if (dl_fall && part_v) begin
         new_a      = stale_w;
         new_a_v    = 1'b1;
         part_v_nxt = 1'b0;
      end
      // A valid skid implies the partial was empty, so new_b cannot be
      // valid here and at most two words are ever in flight.
      if (skid_v) begin
         w0   = skid_w;
         w0_v = 1'b1;
         w1   = new_a;
         w1_v = new_a_v;
      end else begin
         w0   = new_a;
         w0_v = new_a_v;
         w1   = new_b;
         w1_v = new_b_v;
      end
   end

   // Word FIFO with one extra pointer bit to tell full from empty
   word_t       fifo_mem [FIFO_DEPTH];
   logic [PW:0] wr_ptr;
   logic [PW:0] rd_ptr;
   logic [PW:0] wr_ptr_nxt;
   logic [PW:0] rd_ptr_nxt;
   logic        fifo_empty;
   logic        fifo_full;
   logic        pop;
   logic        push_ok;
   logic        push_drop;
   logic        load;
   logic        prog_we_nxt;
   logic        busy_nxt;
   word_t       rd_word;

   assign fifo_empty = (wr_ptr == rd_ptr);
   assign fifo_full  = (wr_ptr[PW] != rd_ptr[PW]) &&
                       (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
   assign pop        = prog_we & prog_ack;
   // The head entry stays in the FIFO while presented; an acknowledge in
   // the same cycle frees its slot for the incoming word.
   assign push_ok    = w0_v & (~fifo_full | pop);
   assign push_drop  = w0_v & fifo_full & ~pop;
   assign load       = ~prog_we & ~fifo_empty;
   assign prog_we_nxt = prog_we ? ~prog_ack : ~fifo_empty;
   assign wr_ptr_nxt = push_ok ? wr_ptr + (PW+1)'(1) : wr_ptr;
   assign rd_ptr_nxt = pop     ? rd_ptr + (PW+1)'(1) : rd_ptr;
   assign rd_word    = fifo_mem[rd_ptr[PW-1:0]];
   // Built from next-state terms so busy drops together with prog_we
   assign busy_nxt   = downloading | (wr_ptr_nxt != rd_ptr_nxt) |
                       part_v_nxt | w1_v | prog_we_nxt;

   // Stage p1: control state
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         downloading_p1 <= 1'b0;
         part_v         <= 1'b0;
         skid_v         <= 1'b0;
         wr_ptr         <= '0;
         rd_ptr         <= '0;
         overflow       <= 1'b0;
         prog_we        <= 1'b0;
         prog_addr      <= '0;
         prog_data      <= '0;
         prog_mask      <= '0;
         dwnld_busy     <= 1'b0;
      end else begin
         downloading_p1 <= downloading;
         part_v         <= part_v_nxt;
         skid_v         <= w1_v;
         wr_ptr         <= wr_ptr_nxt;
         rd_ptr         <= rd_ptr_nxt;
         if (dl_rise)   overflow <= 1'b0;
         if (push_drop) overflow <= 1'b1;
         prog_we        <= prog_we_nxt;
         if (load) begin
            prog_addr <= rd_word.addr;
            prog_data <= rd_word.data;
            prog_mask <= rd_word.mask;
         end
         dwnld_busy     <= busy_nxt;
      end
   end

   // Stage p1: data registers, qualified by the valid bits above
   always_ff @(posedge clk) begin
      part_addr <= part_addr_nxt;
      part_lo   <= part_lo_nxt;
      skid_w    <= w1;
      if (push_ok) fifo_mem[wr_ptr[PW-1:0]] <= w0;
   end

`ifdef JTFRAME_DWNLD_CKSUM_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cksum <= '0;
      end else if (dl_rise) begin
         cksum <= acc ? {8'h00, ioctl_dout} : 16'h0000;
      end else if (acc) begin
         cksum <= cksum + {8'h00, ioctl_dout};
      end
   end
`endif

endmodule

// File: tb/tb_jtframe_dwnld_pack.sv
module tb_jtframe_dwnld_pack;

   localparam int D = 4;

   typedef struct packed {
      logic [21:0] addr;
      logic [15:0] data;
      logic [1:0]  mask;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        downloading;
   logic [24:0] ioctl_addr;
   logic [7:0]  ioctl_dout;
   logic        ioctl_wr;
   logic [21:0] prog_addr;
   logic [15:0] prog_data;
   logic [1:0]  prog_mask;
   logic        prog_we;
   logic        prog_ack;
   logic        dwnld_busy;
   logic        overflow;
`ifdef JTFRAME_DWNLD_CKSUM_EN
   logic [15:0] cksum;
`endif

   int   tests = 0;
   int   fails = 0;
   exp_t sb[$];

   always #5 clk = ~clk;

   jtframe_dwnld_pack #(.SDRAMW(22), .FIFO_DEPTH(D), .SWAB(0)) dut (
      .clk        (clk),
      .rst        (rst),
      .downloading(downloading),
      .ioctl_addr (ioctl_addr),
      .ioctl_dout (ioctl_dout),
      .ioctl_wr   (ioctl_wr),
      .prog_addr  (prog_addr),
      .prog_data  (prog_data),
      .prog_mask  (prog_mask),
      .prog_we    (prog_we),
      .prog_ack   (prog_ack),
      .dwnld_busy (dwnld_busy),
`ifdef JTFRAME_DWNLD_CKSUM_EN
      .cksum      (cksum),
`endif
      .overflow   (overflow)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input int a, input logic [7:0] d);
      ioctl_addr = 25'(a);
      ioctl_dout = d;
      ioctl_wr   = 1'b1;
      step();
      ioctl_wr   = 1'b0;
      step();
   endtask

   task automatic test_reset();
      tests++;
      if ({prog_we, dwnld_busy, overflow} !== 3'b000) begin
         fails++;
         $display("FAIL reset_ctrl got we/busy/ovf=%b required 000", {prog_we, dwnld_busy, overflow});
      end
      tests++;
      if ({prog_addr, prog_data, prog_mask} !== 40'd0) begin
         fails++;
         $display("FAIL reset_data got a=%h d=%h m=%b required zero", prog_addr, prog_data, prog_mask);
      end
      rst = 1'b0;
      step();
      step();
      tests++;
      if ({prog_we, dwnld_busy} !== 2'b00) begin
         fails++;
         $display("FAIL reset_release got we/busy=%b required 00", {prog_we, dwnld_busy});
      end
   endtask

   task automatic test_sequential();
      exp_t e;
      int   n;
      downloading = 1'b1;
      step();
      tests++;
      if (dwnld_busy !== 1'b1) begin
         fails++;
         $display("FAIL seq_busy_dl got %b required 1", dwnld_busy);
      end
      sb.push_back('{22'd0, 16'h2211, 2'b00});
      sb.push_back('{22'd1, 16'h4433, 2'b00});
      send_byte(0, 8'h11);
      send_byte(1, 8'h22);
      send_byte(2, 8'h33);
      send_byte(3, 8'h44);
      downloading = 1'b0;
      n = 0;
      while (sb.size() > 0 && n < 100) begin
         step();
         n++;
         if (prog_we === 1'b1) begin
            e = sb.pop_front();
            tests++;
            if ({prog_addr, prog_data, prog_mask} !== e) begin
               fails++;
               $display("FAIL seq_word got a=%h d=%h m=%b required a=%h d=%h m=%b",
                        prog_addr, prog_data, prog_mask, e.addr, e.data, e.mask);
            end
            step();
            tests++;
            if ({prog_we, dwnld_busy, prog_addr, prog_data, prog_mask} !== {2'b11, e}) begin
               fails++;
               $display("FAIL seq_hold got we=%b busy=%b a=%h d=%h m=%b",
                        prog_we, dwnld_busy, prog_addr, prog_data, prog_mask);
            end
            prog_ack = 1'b1;
            step();
            prog_ack = 1'b0;
            tests++;
            if (prog_we !== 1'b0) begin
               fails++;
               $display("FAIL seq_we_drop got %b required 0", prog_we);
            end
            if (sb.size() == 0) begin
               tests++;
               if (dwnld_busy !== 1'b0) begin
                  fails++;
                  $display("FAIL seq_busy_end got %b required 0", dwnld_busy);
               end
            end
         end
      end
      tests++;
      if (sb.size() != 0) begin
         fails++;
         $display("FAIL seq_timeout got %0d words left required 0", sb.size());
         sb.delete();
      end
   endtask

   task automatic test_partial_words();
      exp_t e;
      int   n;
      downloading = 1'b1;
      step();
      sb.push_back('{22'd4,  16'h5A00, 2'b01});
      sb.push_back('{22'd10, 16'h0010, 2'b10});
      sb.push_back('{22'd15, 16'h7700, 2'b01});
      sb.push_back('{22'd3,  16'h00AB, 2'b10});
      ioctl_addr = 25'd9;
      ioctl_dout = 8'h5A;
      ioctl_wr   = 1'b1;
      step();
      ioctl_wr   = 1'b0;
      tests++;
      if (prog_we !== 1'b0) begin
         fails++;
         $display("FAIL lat_early got we=%b required 0", prog_we);
      end
      step();
      tests++;
      if (prog_we !== 1'b1) begin
         fails++;
         $display("FAIL lat_two got we=%b required 1", prog_we);
      end
      send_byte(20, 8'h10);
      send_byte(31, 8'h77);
      send_byte(6,  8'hAB);
      downloading = 1'b0;
      n = 0;
      while (sb.size() > 0 && n < 100) begin
         step();
         n++;
         if (prog_we === 1'b1) begin
            e = sb.pop_front();
            tests++;
            if ({prog_addr, prog_data, prog_mask} !== e) begin
               fails++;
               $display("FAIL part_word got a=%h d=%h m=%b required a=%h d=%h m=%b",
                        prog_addr, prog_data, prog_mask, e.addr, e.data, e.mask);
            end
            step();
            prog_ack = 1'b1;
            step();
            prog_ack = 1'b0;
         end
      end
      tests++;
      if (sb.size() != 0) begin
         fails++;
         $display("FAIL part_timeout got %0d words left required 0", sb.size());
         sb.delete();
      end
      tests++;
      if (overflow !== 1'b0) begin
         fails++;
         $display("FAIL part_ovf got %b required 0", overflow);
      end
   endtask

   task automatic test_overflow();
      exp_t e;
      int   n;
      int   extra;
      downloading = 1'b1;
      step();
      for (int i = 0; i < 2*(D+2); i++) begin
         if (i % 2 == 1 && i / 2 < D)
            sb.push_back('{22'(32 + i/2), {8'(8'h80 + i), 8'(8'h80 + i - 1)}, 2'b00});
         send_byte(64 + i, 8'(8'h80 + i));
      end
      step();
      tests++;
      if (overflow !== 1'b1) begin
         fails++;
         $display("FAIL ovf_set got %b required 1", overflow);
      end
      downloading = 1'b0;
      n = 0;
      while (sb.size() > 0 && n < 100) begin
         step();
         n++;
         if (prog_we === 1'b1) begin
            e = sb.pop_front();
            tests++;
            if ({prog_addr, prog_data, prog_mask} !== e) begin
               fails++;
               $display("FAIL ovf_word got a=%h d=%h m=%b required a=%h d=%h m=%b",
                        prog_addr, prog_data, prog_mask, e.addr, e.data, e.mask);
            end
            step();
            prog_ack = 1'b1;
            step();
            prog_ack = 1'b0;
         end
      end
      tests++;
      if (sb.size() != 0) begin
         fails++;
         $display("FAIL ovf_timeout got %0d words left required 0", sb.size());
         sb.delete();
      end
      extra = 0;
      for (int i = 0; i < 10; i++) begin
         step();
         if (prog_we === 1'b1) extra++;
      end
      tests++;
      if (extra != 0) begin
         fails++;
         $display("FAIL ovf_extra got %0d cycles of prog_we required 0", extra);
      end
      tests++;
      if (overflow !== 1'b1) begin
         fails++;
         $display("FAIL ovf_sticky got %b required 1", overflow);
      end
      downloading = 1'b1;
      step();
      tests++;
      if (overflow !== 1'b0) begin
         fails++;
         $display("FAIL ovf_clear got %b required 0", overflow);
      end
      downloading = 1'b0;
      step();
      step();
   endtask

   task automatic test_reset_midflight();
      int seen;
      downloading = 1'b1;
      step();
      for (int i = 0; i < 2*(D+2); i++) send_byte(200 + i, 8'(i));
      step();
      tests++;
      if ({prog_we, overflow} !== 2'b11) begin
         fails++;
         $display("FAIL rstmid_pre got we/ovf=%b required 11", {prog_we, overflow});
      end
      rst = 1'b1;
      #1;
      tests++;
      if ({prog_we, dwnld_busy, overflow} !== 3'b000) begin
         fails++;
         $display("FAIL rstmid_async got we/busy/ovf=%b required 000", {prog_we, dwnld_busy, overflow});
      end
      downloading = 1'b0;
      step();
      step();
      rst = 1'b0;
      seen = 0;
      for (int i = 0; i < 20; i++) begin
         step();
         if (prog_we === 1'b1) seen++;
      end
      tests++;
      if (seen != 0 || dwnld_busy !== 1'b0) begin
         fails++;
         $display("FAIL rstmid_stale got %0d we cycles busy=%b required 0 and 0", seen, dwnld_busy);
      end
   endtask

`ifdef JTFRAME_DWNLD_CKSUM_EN
   task automatic test_cksum();
      int acked;
      int n;
      downloading = 1'b1;
      step();
      acked = 0;
      fork
         begin
            for (int i = 0; i < 300; i++) begin
               send_byte(i, 8'hFF);
               step();
               step();
            end
         end
         begin
            for (int c = 0; c < 5000 && acked < 150; c++) begin
               step();
               if (prog_we === 1'b1) begin
                  step();
                  prog_ack = 1'b1;
                  step();
                  prog_ack = 1'b0;
                  acked++;
               end
            end
         end
      join
      tests++;
      if (acked != 150) begin
         fails++;
         $display("FAIL ck_words got %0d acked required 150", acked);
      end
      tests++;
      if (cksum !== 16'h2AD4) begin
         fails++;
         $display("FAIL ck_sum got %h required 2ad4", cksum);
      end
      downloading = 1'b0;
      step();
      send_byte(0, 8'h33);
      tests++;
      if (cksum !== 16'h2AD4) begin
         fails++;
         $display("FAIL ck_frozen got %h required 2ad4", cksum);
      end
      downloading = 1'b1;
      step();
      tests++;
      if (cksum !== 16'h0000) begin
         fails++;
         $display("FAIL ck_clear got %h required 0000", cksum);
      end
      send_byte(0, 8'h05);
      send_byte(1, 8'h07);
      tests++;
      if (cksum !== 16'h000C) begin
         fails++;
         $display("FAIL ck_second got %h required 000c", cksum);
      end
      downloading = 1'b0;
      n = 0;
      while (prog_we !== 1'b1 && n < 20) begin
         step();
         n++;
      end
      tests++;
      if ({prog_we, prog_addr, prog_data, prog_mask} !== {1'b1, 22'd0, 16'h0705, 2'b00}) begin
         fails++;
         $display("FAIL ck_word got we=%b a=%h d=%h m=%b required 1 0 0705 00",
                  prog_we, prog_addr, prog_data, prog_mask);
      end
      prog_ack = 1'b1;
      step();
      prog_ack = 1'b0;
      step();
   endtask
`endif

   initial begin
      rst         = 1'b1;
      downloading = 1'b0;
      ioctl_addr  = '0;
      ioctl_dout  = '0;
      ioctl_wr    = 1'b0;
      prog_ack    = 1'b0;
      step();
      step();
      test_reset();
      test_sequential();
      test_partial_words();
      test_overflow();
      test_reset_midflight();
`ifdef JTFRAME_DWNLD_CKSUM_EN
      test_cksum();
`endif
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
